// File: rtl/counter_seq_ctrl_if.sv
// Signal bundle between the register/control layer, the sequencer and the
// 8-bit loadable up-counter it drives.
interface counter_seq_ctrl_if #(
  parameter int WIDTH   = 8,
  parameter int TALLY_W = 8
);
  logic               start;
  logic               stop;
  logic               hold;
  logic               periodic;
  logic [WIDTH-1:0]   start_val;
  logic [WIDTH-1:0]   term_val;
  logic [WIDTH-1:0]   cnt_value;
  logic               cnt_load;
  logic               cnt_enable;
  logic [WIDTH-1:0]   cnt_data;
  logic               busy;
  logic               tc;
  logic [TALLY_W-1:0] periods;

  modport master (
    output start, stop, hold, periodic, start_val, term_val, cnt_value,
    input  cnt_load, cnt_enable, cnt_data, busy, tc, periods
  );

  modport slave (
    input  start, stop, hold, periodic, start_val, term_val, cnt_value,
    output cnt_load, cnt_enable, cnt_data, busy, tc, periods
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequences an external up-counter from a captured start value to a terminal
// value, one-shot or auto-reload, with a terminal-count pulse and period tally.
//
// state | meaning
// IDLE  | waiting for an accepted start
// LOAD  | counter load strobe, one cycle
// RUN   | counting toward term_reg; match ends the period
module counter_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TALLY_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  counter_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   start_reg;
  logic [WIDTH-1:0]   term_reg;
  logic               mode_reg;
  logic               tc_q;
  logic [TALLY_W-1:0] periods_q;
  logic               accept;
  logic               period_done;
  logic               match;

  // Match is evaluated regardless of hold so a held counter sitting on the
  // terminal value still completes its period.
  assign match = (state == RUN) && (bus.cnt_value == term_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    period_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = bus.stop ? IDLE : RUN;
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (match) begin
          period_done = 1'b1;
          state_nxt   = mode_reg ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_reg <= '0;
      term_reg  <= '0;
      mode_reg  <= 1'b0;
      tc_q      <= 1'b0;
      periods_q <= '0;
    end else begin
      tc_q <= period_done;
      if (accept) begin
        start_reg <= bus.start_val;
        term_reg  <= bus.term_val;
        mode_reg  <= bus.periodic;
        periods_q <= '0;
      end else if (period_done && (periods_q != TALLY_MAX)) begin
        periods_q <= periods_q + TALLY_W'(1);
      end
    end
  end

  assign bus.cnt_data   = start_reg;
  assign bus.cnt_load   = (state == LOAD);
  assign bus.cnt_enable = (state == RUN) && !bus.hold && (bus.cnt_value != term_reg);
  assign bus.busy       = (state != IDLE);
  assign bus.tc         = tc_q;
  assign bus.periods    = periods_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench: directed plan scenarios plus random traffic, compared
// every cycle against a period/position reference model.
module tb_counter_seq_ctrl;
  localparam int W  = 8;
  localparam int TW = 8;
  localparam int TALLY_MAX = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_seq_ctrl_if #(.WIDTH(W), .TALLY_W(TW)) bus ();

  counter_seq_ctrl #(.WIDTH(W), .TALLY_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The 8-bit loadable up-counter the sequencer drives; shares rst_n.
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (bus.cnt_load)   cnt_q <= bus.cnt_data;
    else if (bus.cnt_enable) cnt_q <= cnt_q + W'(1);
  end
  assign bus.cnt_value = cnt_q;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: active/loading flags, captured values, and how many
  // enable steps of the current period have happened.
  bit         m_act, m_ld, m_mode, m_tc;
  logic [W-1:0] m_s, m_t;
  int         m_done, m_per;

  function automatic int span();
    logic [W-1:0] d;
    d = m_t - m_s;
    return int'(d);
  endfunction

  task automatic model_reset();
    m_act = 0; m_ld = 0; m_mode = 0; m_tc = 0;
    m_s = '0; m_t = '0; m_done = 0; m_per = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_tc = 0;
      if (!m_act) begin
        if (bus.start && !bus.stop) begin
          m_act = 1; m_ld = 1;
          m_s = bus.start_val; m_t = bus.term_val; m_mode = bus.periodic;
          m_per = 0;
        end
      end else if (bus.stop) begin
        m_act = 0;
      end else if (m_ld) begin
        m_ld = 0; m_done = 0;
      end else if (m_done == span()) begin
        m_tc = 1;
        if (m_per < TALLY_MAX) m_per++;
        if (m_mode) m_ld = 1; else m_act = 0;
      end else if (!bus.hold) begin
        m_done++;
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_en;
    logic [W-1:0] exp_cv;
    exp_en = m_act && !m_ld && !bus.hold && (m_done != span());
    exp_cv = m_s + W'(m_done);
    chk_eq("busy",       32'(bus.busy),       32'(m_act));
    chk_eq("tc",         32'(bus.tc),         32'(m_tc));
    chk_eq("periods",    32'(bus.periods),    32'(m_per));
    chk_eq("cnt_load",   32'(bus.cnt_load),   32'(m_act && m_ld));
    chk_eq("cnt_enable", 32'(bus.cnt_enable), 32'(exp_en));
    chk_eq("cnt_data",   32'(bus.cnt_data),   32'(m_s));
    if (m_act && !m_ld) chk_eq("cnt_value", 32'(bus.cnt_value), 32'(exp_cv));
  endtask

  int tc_cnt, en_cnt, ld_cnt;
  bit last_tc;

  task automatic cycle(input bit st, input bit sp, input bit hd, input bit pe,
                       input logic [W-1:0] sv, input logic [W-1:0] tv);
    @(negedge clk);
    bus.start = st; bus.stop = sp; bus.hold = hd; bus.periodic = pe;
    bus.start_val = sv; bus.term_val = tv;
    #1;
    check_outputs();
    last_tc = bus.tc;
    if (bus.tc)         tc_cnt++;
    if (bus.cnt_enable) en_cnt++;
    if (bus.cnt_load)   ld_cnt++;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      cycle(1'b0, 1'b0, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic clear_counts();
    tc_cnt = 0; en_cnt = 0; ld_cnt = 0;
  endtask

  task automatic run_oneshot(input int hold_at, input int hold_len, output int lat);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      cycle(1'b0, 1'b0, (i >= hold_at) && (i < hold_at + hold_len),
            1'($urandom), 8'($urandom), 8'($urandom));
      if (last_tc) lat = i;
    end
    if (lat == 0) chk_eq("oneshot_timeout", 32'd0, 32'd1);
  endtask

  int lat0, lath;

  initial begin
    bus.start = 0; bus.stop = 0; bus.hold = 0; bus.periodic = 0;
    bus.start_val = '0; bus.term_val = '0;
    model_reset();
    clear_counts();

    // Reset state, then release away from the clock edge.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 8'hBB);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #3 rst_n = 1'b1;

    // One-shot 0x10 -> 0x14
    clear_counts();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h14);
    idle(10);
    #1;
    chk_eq("os_tc_count", 32'(tc_cnt), 32'd1);
    chk_eq("os_enables",  32'(en_cnt), 32'd4);
    chk_eq("os_loads",    32'(ld_cnt), 32'd1);
    chk_eq("os_periods",  32'(bus.periods), 32'd1);
    chk_eq("os_final_cnt", 32'(bus.cnt_value), 32'h14);

    // Periodic wrap 0xFE -> 0x01, three periods then stop
    clear_counts();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'hFE, 8'h01);
    idle(16);
    #1;
    chk_eq("per_tc_count", 32'(tc_cnt), 32'd3);
    chk_eq("per_periods",  32'(bus.periods), 32'd3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk_eq("per_stop_busy", 32'(bus.busy), 32'd0);
    idle(2);

    // Hold delays tc by exactly the hold length
    clear_counts();
    run_oneshot(0, 0, lat0);
    idle(2);
    run_oneshot(3, 3, lath);
    idle(2);
    chk_eq("nohold_latency", 32'(lat0), 32'd6);
    chk_eq("hold_delay",     32'(lath - lat0), 32'd3);

    // start == term: immediate match, no enables
    clear_counts();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 8'h55);
    idle(5);
    chk_eq("eq_tc_count", 32'(tc_cnt), 32'd1);
    chk_eq("eq_enables",  32'(en_cnt), 32'd0);

    // start and stop together in IDLE
    clear_counts();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 8'h44);
    idle(3);
    chk_eq("ss_loads", 32'(ld_cnt), 32'd0);
    chk_eq("ss_busy",  32'(bus.busy), 32'd0);

    // start while busy is ignored
    clear_counts();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h30);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h05);
    idle(25);
    #1;
    chk_eq("busy_start_tc",   32'(tc_cnt), 32'd1);
    chk_eq("busy_start_data", 32'(bus.cnt_data), 32'h20);
    chk_eq("busy_start_cnt",  32'(bus.cnt_value), 32'h30);

    // stop on the second match cycle of a periodic run
    clear_counts();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 8'h42);
    idle(7);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    #1;
    chk_eq("stop_match_tc",      32'(tc_cnt), 32'd1);
    chk_eq("stop_match_periods", 32'(bus.periods), 32'd1);

    // Asynchronous reset mid-run
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80);
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk_eq("rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("rst_cnt",  32'(bus.cnt_value), 32'd0);
    idle(1);
    #3 rst_n = 1'b1;
    idle(2);

    // Saturation of the period tally
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    idle(620);
    #1;
    chk_eq("sat_periods", 32'(bus.periods), 32'(TALLY_MAX));
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] sv;
      sv = 8'($urandom);
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 3) == 0, 1'($urandom),
            sv, sv + 8'($urandom_range(0, 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
